conv_window_streamer: RTL and testbench

Streaming 3x3 window generator that feeds the convolution engine. It accepts a raster-order pixel stream on an AXI4-Stream slave and holds a 9-entry kernel register file. For every valid (unpadded) 3x3 window position it emits one AXI4-Stream beat carrying 9 image bytes followed by 9 kernel bytes. It sits directly upstream of the convolution engine's slave port and is the transmitter for that 18-byte beat format.

---
 rtl/conv_window_streamer.sv | 200 ++++++++++++++++++++
 tb/tb_conv_window_streamer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_streamer.sv
// conv_window_streamer
//
// Streaming 3x3 window generator for the convolution engine. Pixels arrive in
// raster order on an AXI4-Stream slave. Two line buffers hold the two previous
// rows, and a 3x3 window slides across the image. For every unpadded window
// position the block emits one AXI4-Stream beat. Each beat holds 9 image
// bytes followed by the 9 kernel bytes that were current when the beat was
// loaded. No arithmetic is done here; data passes through unmodified.
//
// Optional feature: define CNN_WIN_TLAST_EN to add m_axis_tlast. It marks the
// last window of each frame.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   s_axis_*        pixel stream in (tdata/tvalid/tready)
//   ker_wr_*        kernel register write port (addr 0..8, 9..15 ignored)
//   m_axis_*        window beat out (tdata = 18 elements, tvalid/tready)
//   m_axis_tlast    last beat of frame (only with CNN_WIN_TLAST_EN)

module conv_window_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       ker_wr_en,
  input  logic [3:0]                 ker_wr_addr,
  input  logic [DATA_WIDTH-1:0]      ker_wr_data,
  output logic [DATA_WIDTH*18-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
`ifdef CNN_WIN_TLAST_EN
  ,
  output logic                       m_axis_tlast
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int BW = DATA_WIDTH * 18;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q       [0:2][0:2];
  logic [DATA_WIDTH-1:0] win_d       [0:2][0:2];
  logic [DATA_WIDTH-1:0] win_shift_s [0:2][0:2];
  logic [DATA_WIDTH-1:0] ker_q [0:8];
  logic [DATA_WIDTH-1:0] ker_d [0:8];
  logic [DATA_WIDTH-1:0] lb0_q [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb0_d [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb1_q [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb1_d [0:IMG_WIDTH-1];
  logic [BW-1:0]         tdata_q, tdata_d, beat_s;
  logic                  tvalid_q, tvalid_d;
  logic                  accept_s, emit_s;
`ifdef CNN_WIN_TLAST_EN
  logic                  tlast_q, tlast_d;
`endif

  // The single output register frees up in the same cycle it drains, so there
  // is no bubble at full rate. Ready is also forced high during reset.
  assign s_axis_tready = !aresetn || !tvalid_q || m_axis_tready;
  assign accept_s      = aresetn && s_axis_tvalid && s_axis_tready;
  // Windows that overlap the top two rows or the left two columns are padded
  // positions and are never emitted.
  assign emit_s        = accept_s && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
`ifdef CNN_WIN_TLAST_EN
  assign m_axis_tlast  = tlast_q;
`endif

  // Window after shifting left and loading the incoming column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_shift_s[r][0] = win_q[r][1];
      win_shift_s[r][1] = win_q[r][2];
    end
    win_shift_s[0][2] = lb0_q[col_q];
    win_shift_s[1][2] = lb1_q[col_q];
    win_shift_s[2][2] = s_axis_tdata;
  end

  // Pack the post-shift window and the current kernel into one beat.
  always_comb begin
    beat_s = {BW{1'b0}};
    for (int i = 0; i < 9; i++) begin
      beat_s[i*DATA_WIDTH +: DATA_WIDTH]     = win_shift_s[i/3][i%3];
      beat_s[(i+9)*DATA_WIDTH +: DATA_WIDTH] = ker_q[i];
    end
  end

  // Position counters, window update and output register next state.
  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
`ifdef CNN_WIN_TLAST_EN
    tlast_d  = tlast_q;
`endif
    if (accept_s) begin
      win_d = win_shift_s;
      if (col_q == COL_LAST) begin
        col_d = {CW{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {RW{1'b0}};
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        row_d = row_q;
      end
    end else begin
      win_d = win_q;
    end
    if (emit_s) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_s;
`ifdef CNN_WIN_TLAST_EN
      tlast_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
`endif
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Line buffers move one row down at the accepted column.
  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    if (accept_s) begin
      lb0_d[col_q] = lb1_q[col_q];
      lb1_d[col_q] = s_axis_tdata;
    end else begin
      lb1_d = lb1_q;
    end
  end

  // Kernel register file writes; out-of-range addresses are dropped.
  always_comb begin
    ker_d = ker_q;
    if (ker_wr_en && (ker_wr_addr < 4'd9)) begin
      ker_d[ker_wr_addr] = ker_wr_data;
    end else begin
      ker_d = ker_q;
    end
  end

  // Control, window, kernel and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      col_q    <= {CW{1'b0}};
      row_q    <= {RW{1'b0}};
      tvalid_q <= 1'b0;
      tdata_q  <= {BW{1'b0}};
`ifdef CNN_WIN_TLAST_EN
      tlast_q  <= 1'b0;
`endif
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= {DATA_WIDTH{1'b0}};
        end
      end
      for (int k = 0; k < 9; k++) begin
        ker_q[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
`ifdef CNN_WIN_TLAST_EN
      tlast_q  <= tlast_d;
`endif
      win_q    <= win_d;
      ker_q    <= ker_d;
    end
  end

  // Line buffers are deliberately not reset: emission needs row >= 2, so
  // stale contents are always overwritten before they can reach a beat.
  always_ff @(posedge aclk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

endmodule

// File: tb/tb_conv_window_streamer.sv
// Self-checking bench for conv_window_streamer: a 4x4 instance is checked every
// cycle against an image-array model, and a default 28x28 instance is checked
// for beat count and first-beat latency.

module tb_conv_window_streamer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic          ker_wr_en = 1'b0;
  logic [3:0]    ker_wr_addr = 4'd0;
  logic [7:0]    ker_wr_data = 8'd0;
  logic [143:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
`ifdef CNN_WIN_TLAST_EN
  logic          m_tlast;
  logic          b_tlast;
`endif

  logic [7:0]    b_data = 8'd0;
  logic          b_tvalid = 1'b0;
  logic          b_tready;
  logic [143:0]  b_mdata;
  logic          b_mvalid;
  logic          b_mready = 1'b1;
  logic          b_kwe = 1'b0;
  logic [3:0]    b_kaddr = 4'd0;
  logic [7:0]    b_kdata = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0;

  // behavioural model state
  logic [7:0]   pix [0:H-1][0:W-1];
  logic [7:0]   mker [0:8];
  int           pos = 0;
  bit           ev = 1'b0;
  bit           known = 1'b0;
  bit           el = 1'b0;
  logic [143:0] ed = 144'd0;
  bit           m_acc = 1'b0;

  logic [143:0] got_q [$];
  bit           got_l [$];

  conv_window_streamer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .ker_wr_en(ker_wr_en), .ker_wr_addr(ker_wr_addr), .ker_wr_data(ker_wr_data),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef CNN_WIN_TLAST_EN
    , .m_axis_tlast(m_tlast)
`endif
  );

  conv_window_streamer u_big (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(b_data), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .ker_wr_en(b_kwe), .ker_wr_addr(b_kaddr), .ker_wr_data(b_kdata),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready)
`ifdef CNN_WIN_TLAST_EN
    , .m_axis_tlast(b_tlast)
`endif
  );

  initial forever #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: image held as a 2D array indexed by frame position.
  always @(posedge aclk) begin
    int r, c;
    m_acc = 1'b0;
    if (!aresetn) begin
      ev = 1'b0; known = 1'b1; ed = 144'd0; el = 1'b0; pos = 0;
      for (int k = 0; k < 9; k++) mker[k] = 8'd0;
    end else begin
      m_acc = s_tvalid && (!ev || m_tready);
      if (ev && m_tready) begin
        ev = 1'b0; known = 1'b0;
      end
      if (m_acc) begin
        r = pos / W;
        c = pos % W;
        pix[r][c] = s_data;
        if (r >= 2 && c >= 2) begin
          for (int i = 0; i < 9; i++) begin
            ed[i*8 +: 8]     = pix[r-2+i/3][c-2+i%3];
            ed[(i+9)*8 +: 8] = mker[i];
          end
          ev = 1'b1; known = 1'b1;
          el = (r == H-1) && (c == W-1);
        end
        pos = (pos + 1) % (W*H);
      end
      if (ker_wr_en && ker_wr_addr < 4'd9) mker[ker_wr_addr] = ker_wr_data;
    end
  end

  // Per-cycle comparison against the model, plus capture of delivered beats.
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("s_tready", {143'd0, s_tready}, {143'd0, (!aresetn || !ev || m_tready)});
      chk("m_tvalid", {143'd0, m_tvalid}, {143'd0, ev});
      if (known) chk("m_tdata", m_tdata, ed);
`ifdef CNN_WIN_TLAST_EN
      if (known) chk("m_tlast", {143'd0, m_tlast}, {143'd0, el});
`endif
      if (m_tvalid && m_tready) begin
        got_q.push_back(m_tdata);
`ifdef CNN_WIN_TLAST_EN
        got_l.push_back(m_tlast);
`else
        got_l.push_back(1'b0);
`endif
      end
    end
  end

  // Downstream ready driver: 0 always ready, 1 pattern 1-0-0-1, 2 random.
  initial begin
    int cyc = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        1:       m_tready = pat[cyc % 4];
        2:       m_tready = ($urandom % 3) != 0;
        default: m_tready = 1'b1;
      endcase
      cyc++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic send_pix(input logic [7:0] v);
    int t = 0;
    s_tvalid = 1'b1;
    s_data = v;
    do begin @(posedge aclk); #1; t++; end while (!m_acc && t < 64);
    if (!m_acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: pixel %0d not accepted within 64 cycles", v);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < W*H; i++) send_pix(8'(base + i));
  endtask

  task automatic ker_write(input logic [3:0] a, input logic [7:0] d);
    ker_wr_en = 1'b1; ker_wr_addr = a; ker_wr_data = d;
    idle(1);
    ker_wr_en = 1'b0;
  endtask

  localparam logic [71:0] IMG1 = 72'h0b0a09_070605_030201;
  localparam logic [71:0] IMG2 = 72'h0c0b0a_080706_040302;
  localparam logic [71:0] IMG3 = 72'h0f0e0d_0b0a09_070605;
  localparam logic [71:0] IMG4 = 72'h100f0e_0c0b0a_080706;
  localparam logic [71:0] IMG5 = 72'h1b1a19_171615_131211;
  localparam logic [71:0] IMG8 = 72'h201f1e_1c1b1a_181716;
  localparam logic [71:0] K1   = 72'h01_01_01_01_01_01_01_01_01;
  localparam logic [71:0] K5   = 72'h01_01_01_01_05_01_01_01_01;

  initial begin
    int bcnt;
    // reset
    @(posedge aclk); #1;
    chk_en = 1'b1;
    idle(2);
    chk("rst_tvalid", {143'd0, m_tvalid}, 144'd0);
    chk("rst_tdata", m_tdata, 144'd0);
    chk("rst_s_tready", {143'd0, s_tready}, 144'd1);
    aresetn = 1'b1;
    idle(1);
    chk("post_rst_s_tready", {143'd0, s_tready}, 144'd1);

    // 1: basic frame, kernel all ones
    for (int k = 0; k < 9; k++) ker_write(4'(k), 8'h01);
    got_q.delete(); got_l.delete();
    send_frame(1);
    idle(6);
    chk("t1_count", 144'(got_q.size()), 144'd4);
    if (got_q.size() >= 4) begin
      chk("t1_b1", got_q[0], {K1, IMG1});
      chk("t1_b2", got_q[1], {K1, IMG2});
      chk("t1_b3", got_q[2], {K1, IMG3});
      chk("t1_b4", got_q[3], {K1, IMG4});
    end

    // 2: same frame with backpressure pattern
    rdy_mode = 1;
    got_q.delete(); got_l.delete();
    send_frame(1);
    idle(14);
    rdy_mode = 0;
    idle(1);
    chk("t2_count", 144'(got_q.size()), 144'd4);
    if (got_q.size() >= 4) begin
      chk("t2_b1", got_q[0], {K1, IMG1});
      chk("t2_b2", got_q[1], {K1, IMG2});
      chk("t2_b3", got_q[2], {K1, IMG3});
      chk("t2_b4", got_q[3], {K1, IMG4});
    end

    // 3: kernel write between beats 2 and 3; write to addr 12 is dropped
    got_q.delete(); got_l.delete();
    for (int i = 0; i < W*H; i++) begin
      if (i == 12) begin ker_wr_en = 1'b1; ker_wr_addr = 4'd4;  ker_wr_data = 8'h05; end
      if (i == 13) begin ker_wr_en = 1'b1; ker_wr_addr = 4'd12; ker_wr_data = 8'h77; end
      send_pix(8'(1 + i));
      ker_wr_en = 1'b0;
    end
    idle(6);
    chk("t3_count", 144'(got_q.size()), 144'd4);
    if (got_q.size() >= 4) begin
      chk("t3_b1", got_q[0], {K1, IMG1});
      chk("t3_b2", got_q[1], {K1, IMG2});
      chk("t3_b3", got_q[2], {K5, IMG3});
      chk("t3_b4", got_q[3], {K5, IMG4});
    end
    ker_write(4'd4, 8'h01);

    // 4: two back-to-back frames
    got_q.delete(); got_l.delete();
    send_frame(1);
    send_frame(17);
    idle(6);
    chk("t4_count", 144'(got_q.size()), 144'd8);
    if (got_q.size() >= 8) begin
      chk("t4_b1", got_q[0], {K1, IMG1});
      chk("t4_b4", got_q[3], {K1, IMG4});
      chk("t4_b5", got_q[4], {K1, IMG5});
      chk("t4_b8", got_q[7], {K1, IMG8});
`ifdef CNN_WIN_TLAST_EN
      for (int j = 0; j < 8; j++)
        chk("t4_tlast", {143'd0, got_l[j]}, {143'd0, (j == 3 || j == 7)});
`endif
    end

    // 5: reset mid-frame, then a fresh frame with cleared kernel
    for (int i = 0; i < 9; i++) send_pix(8'(1 + i));
    aresetn = 1'b0;
    idle(3);
    chk("t5_rst_tvalid", {143'd0, m_tvalid}, 144'd0);
    chk("t5_rst_tdata", m_tdata, 144'd0);
    aresetn = 1'b1;
    got_q.delete(); got_l.delete();
    send_frame(1);
    idle(6);
    chk("t5_count", 144'(got_q.size()), 144'd4);
    if (got_q.size() >= 4) begin
      chk("t5_b1", got_q[0], {72'd0, IMG1});
      chk("t5_b4", got_q[3], {72'd0, IMG4});
    end

    // 6: randomized traffic, kernel writes, backpressure and occasional reset
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      s_tvalid    = ($urandom % 4) != 0;
      s_data      = 8'($urandom);
      ker_wr_en   = ($urandom % 6) == 0;
      ker_wr_addr = 4'($urandom);
      ker_wr_data = 8'($urandom);
      aresetn     = ($urandom % 300) != 0;
      idle(1);
    end
    s_tvalid = 1'b0; ker_wr_en = 1'b0; aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    rdy_mode = 0;
    idle(4);

    // 7: default 28x28 instance at full rate
    bcnt = 0;
    for (int k = 0; k < 786; k++) begin
      @(posedge aclk); #1;
      b_tvalid = (k < 784);
      b_data   = 8'(k + 1);
      @(negedge aclk);
      if (b_mvalid) bcnt++;
      if (k == 58) chk("big_no_early_beat", {143'd0, b_mvalid}, 144'd0);
      if (k == 59) begin
        chk("big_first_valid", {143'd0, b_mvalid}, 144'd1);
        chk("big_first_beat", b_mdata, {72'd0, 72'h3b3a39_1f1e1d_030201});
      end
      if (k < 784) chk("big_s_tready", {143'd0, b_tready}, 144'd1);
    end
    chk("big_beat_count", 144'(bcnt), 144'd676);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
